// File: rtl/cnn_frame_seq.sv
// Frame sequencer: walks a W x H raster over N channel planes with start-up/line
// delays, back-pressure, 3x3 pad flags, stride-2 strobes, abort and frame-done.
module cnn_frame_seq #(
  parameter int W_SIZE       = 12,
  parameter int W_DELAY      = 12,
  parameter int W_CH         = 8,
  parameter int W_FRAME_SIZE = 2*W_SIZE+1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_start,
  input  logic                    q_abort,
  input  logic                    q_is_conv3x3,
  input  logic                    q_stride2,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CH-1:0]         q_channels,
  input  logic [W_DELAY-1:0]      q_start_up_delay,
  input  logic [W_DELAY-1:0]      q_hsync_delay,
  input  logic                    i_ready,
  output logic                    o_ctrl_vsync_run,
  output logic                    o_ctrl_hsync_run,
  output logic                    o_ctrl_data_run,
  output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
  output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CH-1:0]         o_chan,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_fire,
  output logic                    o_pad_top,
  output logic                    o_pad_bot,
  output logic                    o_pad_left,
  output logic                    o_pad_right,
  output logic                    o_stride_hit,
  output logic                    o_end_line,
  output logic                    o_end_plane,
  output logic                    o_end_frame,
  output logic                    o_frame_done,
  output logic                    o_cfg_err,
  output logic                    o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA, S_DONE} state_t;

  localparam logic [W_SIZE-1:0] ONE_S = 1;
  localparam logic [W_CH-1:0]   ONE_C = 1;

  state_t                  state;
  logic [W_DELAY-1:0]      vsync_cnt, hsync_cnt;
  logic [W_SIZE-1:0]       row, col;
  logic [W_CH-1:0]         chan;
  logic [W_FRAME_SIZE-1:0] data_count;
  logic                    cfg_err;

  // Shadow copy of the configuration, frozen for the whole frame
  logic [W_SIZE-1:0]  width_q, height_q;
  logic [W_CH-1:0]    chans_q;
  logic [W_DELAY-1:0] su_delay_q, hs_delay_q;
  logic               conv_q, stride2_q;

  logic [W_SIZE-1:0] width_m1, height_m1;
  logic [W_CH-1:0]   chans_m1;
  logic              data_run, fire, last_col, last_row, end_line, end_plane, end_frame;

  assign width_m1  = width_q - ONE_S;
  assign height_m1 = height_q - ONE_S;
  assign chans_m1  = chans_q - ONE_C;

  assign data_run  = (state == S_DATA);
  assign fire      = data_run & i_ready;
  assign last_col  = (col == width_m1);
  assign last_row  = (row == height_m1);
  assign end_line  = data_run & last_col;
  assign end_plane = end_line & last_row;
  assign end_frame = end_plane & (chan == chans_m1);

  assign o_ctrl_vsync_run = (state == S_VSYNC);
  assign o_ctrl_hsync_run = (state == S_HSYNC);
  assign o_ctrl_data_run  = data_run;
  assign o_ctrl_vsync_cnt = vsync_cnt;
  assign o_ctrl_hsync_cnt = hsync_cnt;
  assign o_row            = row;
  assign o_col            = col;
  assign o_chan           = chan;
  assign o_data_count     = data_count;
  assign o_fire           = fire;
  assign o_pad_top        = data_run & conv_q & (row == '0);
  assign o_pad_bot        = data_run & conv_q & last_row;
  assign o_pad_left       = data_run & conv_q & (col == '0);
  assign o_pad_right      = data_run & conv_q & last_col;
  assign o_stride_hit     = data_run & (~stride2_q | (~row[0] & ~col[0]));
  assign o_end_line       = end_line;
  assign o_end_plane      = end_plane;
  assign o_end_frame      = end_frame;
  assign o_frame_done     = (state == S_DONE);
  assign o_cfg_err        = cfg_err;
  assign o_busy           = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vsync_cnt  <= '0;
      hsync_cnt  <= '0;
      row        <= '0;
      col        <= '0;
      chan       <= '0;
      data_count <= '0;
      cfg_err    <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      chans_q    <= '0;
      su_delay_q <= '0;
      hs_delay_q <= '0;
      conv_q     <= 1'b0;
      stride2_q  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (q_abort && state != S_IDLE) begin
        state      <= S_IDLE;
        vsync_cnt  <= '0;
        hsync_cnt  <= '0;
        row        <= '0;
        col        <= '0;
        chan       <= '0;
        data_count <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (q_start && !q_abort) begin
              if (q_width == '0 || q_height == '0 || q_channels == '0) begin
                cfg_err <= 1'b1;
              end else begin
                width_q    <= q_width;
                height_q   <= q_height;
                chans_q    <= q_channels;
                su_delay_q <= q_start_up_delay;
                hs_delay_q <= q_hsync_delay;
                conv_q     <= q_is_conv3x3;
                stride2_q  <= q_stride2;
                state      <= S_VSYNC;
              end
            end
          end
          S_VSYNC: begin
            if (vsync_cnt == su_delay_q) begin
              vsync_cnt <= '0;
              state     <= S_HSYNC;
            end else begin
              vsync_cnt <= vsync_cnt + 1'b1;
            end
          end
          S_HSYNC: begin
            if (hsync_cnt == hs_delay_q) begin
              hsync_cnt <= '0;
              state     <= S_DATA;
            end else begin
              hsync_cnt <= hsync_cnt + 1'b1;
            end
          end
          S_DATA: begin
            // Stalled pixels hold every coordinate and the state
            if (i_ready) begin
              if (end_frame) begin
                row        <= '0;
                col        <= '0;
                data_count <= '0;
                state      <= S_DONE;
              end else if (end_plane) begin
                chan       <= chan + 1'b1;
                row        <= '0;
                col        <= '0;
                data_count <= '0;
                state      <= S_VSYNC;
              end else if (end_line) begin
                col        <= '0;
                row        <= row + 1'b1;
                data_count <= data_count + 1'b1;
                state      <= S_HSYNC;
              end else begin
                col        <= col + 1'b1;
                data_count <= data_count + 1'b1;
              end
            end
          end
          S_DONE: begin
            chan  <= '0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
